// File: rtl/zf_pkg.sv
// rtl/zf_pkg.sv - shared constants, state type and matrix helpers for the ZF detector stages
//
// Purpose : common definitions for the ZF pipeline (transpose, Gram, inverse, multiply).
//           The 4x4 matrices are packed row-major. Element (r,c) sits at
//           bits [255-16*(4r+c) -: 16], so element (0,0) is in the MSBs.
// Contents: element/fraction/matrix/accumulator widths, the Gram FSM state
//           type, the upper-triangle entry table and the element slice helper.
package zf_pkg;

  localparam int ELEM_W  = 16;
  localparam int FRAC_W  = 12;
  localparam int MAT_W   = 256;
  localparam int ACC_W   = 34;
  localparam int N_ENTRY = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_NORM,
    ST_DONE
  } gram_state_t;

  // Upper-triangle visiting order. Returns {i, j}.
  function automatic logic [3:0] entry_ij(input logic [3:0] n);
    logic [3:0] ij;
    case (n)
      4'd0:    ij = {2'd0, 2'd0};
      4'd1:    ij = {2'd0, 2'd1};
      4'd2:    ij = {2'd0, 2'd2};
      4'd3:    ij = {2'd0, 2'd3};
      4'd4:    ij = {2'd1, 2'd1};
      4'd5:    ij = {2'd1, 2'd2};
      4'd6:    ij = {2'd1, 2'd3};
      4'd7:    ij = {2'd2, 2'd2};
      4'd8:    ij = {2'd2, 2'd3};
      4'd9:    ij = {2'd3, 2'd3};
      default: ij = {2'd0, 2'd0};
    endcase
    return ij;
  endfunction

  // Element (r,c) of a packed matrix. The shift brings the element to the MSBs.
  function automatic logic [ELEM_W-1:0] get_elem(input logic [MAT_W-1:0] m,
                                                 input logic [1:0]       r,
                                                 input logic [1:0]       c);
    logic [MAT_W-1:0] t;
    t = m << (ELEM_W * {r, c});
    return t[MAT_W-1 -: ELEM_W];
  endfunction

endpackage

// File: rtl/sm_mult.sv
// rtl/sm_mult.sv - combinational sign-magnitude multiply with two's-complement result
//
// Purpose : multiplies two sign-magnitude Q3.12 operands and returns the exact
//           Q6.24 product as a sign-extended two's-complement accumulator word.
//           A zero magnitude gives +0, so a negative-zero operand (0x8000)
//           behaves exactly like 0x0000.
// Ports   : a, b [15:0] sign-magnitude operands (in)
//           p    [33:0] two's-complement product (out)
module sm_mult
  import zf_pkg::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ACC_W-1:0]  p
);

  logic [2*ELEM_W-3:0] mag;
  logic                neg;

  always_comb begin
    mag = a[ELEM_W-2:0] * b[ELEM_W-2:0];
    neg = a[ELEM_W-1] ^ b[ELEM_W-1];
    p   = neg ? -ACC_W'(mag) : ACC_W'(mag);
  end

endmodule

// File: rtl/gram_4x4.sv
// rtl/gram_4x4.sv - 4x4 Gram matrix G = H^T*H using one shared MAC
//
// Purpose : forms G(i,j) = sum_k Ht(i,k)*Ht(j,k) from the transposed channel
//           matrix. Only the 10 upper-triangle entries are computed, each over
//           4 MAC cycles plus 1 normalise cycle, and each is mirrored to G(j,i).
// Ports   : clk            rising-edge clock (in)
//           reset          synchronous active-high reset (in)
//           start          one-cycle request, sampled only in IDLE (in)
//           ht_in  [255:0] Ht matrix, captured on the start edge (in)
//           busy           high from the capture edge until done (out)
//           done           one-cycle pulse, result valid from this cycle (out)
//           result [255:0] G matrix, same packing and format as ht_in (out)
module gram_4x4
  import zf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MAT_W-1:0] ht_in,
  output logic             busy,
  output logic             done,
  output logic [MAT_W-1:0] result
);

  localparam logic [ACC_W-1:0] HALF_LSB = ACC_W'(1) << (FRAC_W - 1);
  localparam logic [ACC_W-1:0] MAG_MAX  = ACC_W'(16'h7fff);

  gram_state_t       state, state_n;
  logic [MAT_W-1:0]  ht_q;
  logic [MAT_W-1:0]  result_q;
  logic [3:0]        entry;
  logic [1:0]        k;
  logic [ACC_W-1:0]  acc;

  logic [1:0]        ei, ej;
  logic [ELEM_W-1:0] op_a, op_b;
  logic [ACC_W-1:0]  prod;

  logic [ACC_W-1:0]  rnd;
  logic [ACC_W-1:0]  shifted;
  logic [ACC_W-1:0]  r_abs;
  logic [ELEM_W-2:0] mag;
  logic [ELEM_W-1:0] norm_val;

  // Both operands come from rows i and j of the captured Ht, column k.
  always_comb begin
    {ei, ej} = entry_ij(entry);
    op_a     = get_elem(ht_q, ei, k);
    op_b     = get_elem(ht_q, ej, k);
  end

  sm_mult u_mult (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // Round half up, then arithmetic shift back to Q3.12 and convert to
  // sign-magnitude with saturation. A zero magnitude is forced to +0.
  always_comb begin
    rnd      = acc + HALF_LSB;
    shifted  = $signed(rnd) >>> FRAC_W;
    r_abs    = shifted[ACC_W-1] ? (~shifted + ACC_W'(1)) : shifted;
    mag      = (r_abs > MAG_MAX) ? MAG_MAX[ELEM_W-2:0] : r_abs[ELEM_W-2:0];
    norm_val = (mag == '0) ? '0 : {shifted[ACC_W-1], mag};
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_MAC;
      ST_MAC:  if (k == 2'd3) state_n = ST_NORM;
      ST_NORM: state_n = (entry == 4'(N_ENTRY - 1)) ? ST_DONE : ST_MAC;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    busy = (state == ST_MAC) || (state == ST_NORM);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ht_q     <= '0;
      result_q <= '0;
      entry    <= '0;
      k        <= '0;
      acc      <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ht_q  <= ht_in;
            entry <= '0;
            k     <= '0;
          end
        end
        ST_MAC: begin
          acc <= (k == 2'd0) ? prod : acc + prod;
          k   <= k + 2'd1;
        end
        ST_NORM: begin
          // Write G(i,j) and its mirror G(j,i); on the diagonal both hit the same slot.
          for (int idx = 0; idx < 16; idx++) begin
            if ((idx[3:0] == {ei, ej}) || (idx[3:0] == {ej, ei}))
              result_q[MAT_W-1-ELEM_W*idx -: ELEM_W] <= norm_val;
          end
          entry <= entry + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_gram_4x4.sv
// tb/tb_gram_4x4.sv - scoreboard bench for gram_4x4
module tb_gram_4x4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] ht_in;
  logic         busy;
  logic         done;
  logic [255:0] result;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [255:0] exp_q[$];
  string        tag_q[$];

  gram_4x4 dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ht_in  (ht_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] elem(input logic [255:0] m, input int e);
    logic [255:0] t;
    t = m << (16 * e);
    return t[255:240];
  endfunction

  // Matrix with diagonal d and every off-diagonal element o.
  function automatic logic [255:0] mk(input logic [15:0] d, input logic [15:0] o);
    logic [255:0] m;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[255-16*(4*r+c) -: 16] = (r == c) ? d : o;
    return m;
  endfunction

  // Monitor: every done pops one expected matrix and compares all 16 elements.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 256'(done_cnt), 256'(0));
      end else begin
        logic [255:0] e;
        string        t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        for (int i = 0; i < 16; i++)
          chk($sformatf("%s g[%0d][%0d]", t, i / 4, i % 4), 256'(elem(result, i)), 256'(elem(e, i)));
      end
    end
  end

  task automatic run_job(input string tag, input logic [255:0] ht, input logic [255:0] exp,
                         input bit mid_start, input logic [255:0] ht2);
    int lat;
    bit got;
    @(negedge clk);
    ht_in = ht;
    start = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, 256'(busy), 256'(1));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mid_start && lat == 10) begin
        ht_in = ht2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    chk({tag, " latency"}, 256'(lat), 256'(50));
    chk({tag, " busy_at_done"}, 256'(busy), 256'(0));
  endtask

  logic [255:0] m_sign, g_sign, m_sat, g_sat;

  initial begin
    int dc;
    reset = 1'b1;
    start = 1'b0;
    ht_in = '0;
    m_sign = {16'h1000, 16'h9000, 16'h0000, 16'h0000,
              16'h1000, 16'h1000, 16'h0000, 16'h0000, 128'h0};
    g_sign = {16'h2000, 16'h0000, 16'h0000, 16'h0000,
              16'h0000, 16'h2000, 16'h0000, 16'h0000, 128'h0};
    m_sat  = {16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff,
              16'hffff, 16'hffff, 16'hffff, 16'hffff, 128'h0};
    g_sat  = {16'h7fff, 16'hffff, 16'h0000, 16'h0000,
              16'hffff, 16'h7fff, 16'h0000, 16'h0000, 128'h0};
    repeat (3) @(negedge clk);
    chk("reset busy", 256'(busy), 256'(0));
    chk("reset done", 256'(done), 256'(0));
    chk("reset result", result, 256'(0));
    reset = 1'b0;

    run_job("identity", mk(16'h1000, 16'h0000), mk(16'h1000, 16'h0000), 1'b0, '0);
    run_job("fill_0p2", mk(16'h0333, 16'h0333), mk(16'h028f, 16'h028f), 1'b0, '0);
    run_job("signs", m_sign, g_sign, 1'b0, '0);
    run_job("saturate", m_sat, g_sat, 1'b0, '0);

    // Second start mid-job with a different matrix must be ignored;
    // the follow-up start right after DONE runs that matrix.
    run_job("hs_first", mk(16'h0333, 16'h0333), mk(16'h028f, 16'h028f), 1'b1, m_sign);
    run_job("hs_second", m_sign, g_sign, 1'b0, '0);

    // Reset 25 cycles into a job: everything clears and no done follows.
    @(negedge clk);
    ht_in = m_sat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset busy", 256'(busy), 256'(0));
    chk("midreset done", 256'(done), 256'(0));
    chk("midreset result", result, 256'(0));
    reset = 1'b0;
    dc = done_cnt;
    repeat (60) @(negedge clk);
    chk("midreset no_done", 256'(done_cnt), 256'(dc));
    run_job("post_reset", mk(16'h1000, 16'h0000), mk(16'h1000, 16'h0000), 1'b0, '0);

    repeat (5) @(negedge clk);
    chk("done_count", 256'(done_cnt), 256'(7));
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
